acc_pipe_datapath: RTL

//  Parametrised successor to the 8-bit sequential accumulator/B-register datapath in Risc_Cpu.

---
 rtl/acc_pipe_pkg.sv | 43 ++++
 rtl/pipe_stage.sv | 41 ++++
 rtl/acc_pipe_datapath.sv | 86 ++++++++
 3 files changed

// File: rtl/acc_pipe_pkg.sv
// Shared op encodings and accumulator ALU for the accumulator pipeline datapath.
// The ALU works on a fixed-size container; callers zero-extend and pass their real width.
package acc_pipe_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_INC  = 2'b10;
   localparam logic [1:0] OP_ADD  = 2'b11;

   localparam int ACC_MAX_W = 64;

   // Returns {carry, result}; result bits at and above width are always zero.
   function automatic logic [ACC_MAX_W:0] acc_next(
      input logic [1:0]           op,
      input logic [ACC_MAX_W-1:0] a,
      input logic [ACC_MAX_W-1:0] d,
      input int                   width,
      input logic                 sat
   );
      logic [ACC_MAX_W-1:0] mask;
      logic [ACC_MAX_W-1:0] addend;
      logic [ACC_MAX_W:0]   sum;
      logic [ACC_MAX_W-1:0] res;
      logic                 carry;
      mask   = (width >= ACC_MAX_W) ? {ACC_MAX_W{1'b1}}
                                    : ((64'd1 << width) - 64'd1);
      addend = (op == OP_INC) ? 64'd1 : d;
      sum    = {1'b0, a} + {1'b0, addend};
      carry  = 1'b0;
      res    = {ACC_MAX_W{1'b0}};
      case (op)
         OP_HOLD: res = a & mask;
         OP_LOAD: res = d & mask;
         OP_INC, OP_ADD: begin
            carry = sum[ACC_MAX_W] | (|(sum[ACC_MAX_W-1:0] & ~mask));
            res   = (carry && sat) ? mask : (sum[ACC_MAX_W-1:0] & mask);
         end
         default: res = a & mask;
      endcase
      return {carry, res};
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic register slice with valid/ready handshake and no bubble:
// it accepts whenever empty or when its current content leaves in the same edge.
module pipe_stage #(
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_ready,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   logic          r_valid;
   logic [DW-1:0] r_data;

   assign o_ready = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Slice register: data only moves on a real transfer so a stalled or drained output stays put.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= 1'b0;
         r_data  <= {DW{1'b0}};
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end else begin
            r_data <= r_data;
         end
      end else begin
         r_valid <= r_valid;
         r_data  <= r_data;
      end
   end

endmodule

// File: rtl/acc_pipe_datapath.sv
// Accumulator A plus an elastic STAGES-deep result pipeline; every accepted op
// (HOLD included) pushes a {ovf, A_next} snapshot toward data_out. WIDTH must stay below 64.
import acc_pipe_pkg::*;

module acc_pipe_datapath #(
   parameter int WIDTH    = 8,
   parameter int STAGES   = 2,
   parameter int SAT_MODE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             ovf,
   output logic [WIDTH-1:0] acc
);

   localparam logic SAT_EN = (SAT_MODE != 0);

   logic [WIDTH-1:0]            r_acc;
   logic [ACC_MAX_W-1:0]        w_a_ext;
   logic [ACC_MAX_W-1:0]        w_d_ext;
   logic [ACC_MAX_W:0]          w_alu;
   logic [WIDTH-1:0]            w_acc_next;
   logic                        w_alu_ovf;
   logic                        w_unused_hi;
   logic                        w_accept;
   logic [STAGES:0]             w_valid;
   logic [STAGES:0][WIDTH:0]    w_data;

   assign w_a_ext     = {{(ACC_MAX_W-WIDTH){1'b0}}, r_acc};
   assign w_d_ext     = {{(ACC_MAX_W-WIDTH){1'b0}}, data_in};
   assign w_alu       = acc_next(op, w_a_ext, w_d_ext, WIDTH, SAT_EN);
   assign w_acc_next  = w_alu[WIDTH-1:0];
   assign w_alu_ovf   = w_alu[ACC_MAX_W];
   assign w_unused_hi = ^w_alu[ACC_MAX_W-1:WIDTH];

   assign w_accept    = in_valid && in_ready;

   // Accumulator only moves on an accepted op, so a full pipe freezes it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc <= {WIDTH{1'b0}};
      end else if (w_accept) begin
         r_acc <= w_acc_next;
      end else begin
         r_acc <= r_acc;
      end
   end

   assign w_valid[0] = in_valid;
   assign w_data[0]  = {w_alu_ovf, w_acc_next};

   // Ready ripples back from out_ready through each slice within the same cycle.
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic w_rdy_up;
      logic w_rdy_dn;
      if (g == STAGES-1) begin : g_tail
         assign w_rdy_dn = out_ready;
      end else begin : g_mid
         assign w_rdy_dn = g_stage[g+1].w_rdy_up;
      end
      pipe_stage #(.DW(WIDTH+1)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .i_valid (w_valid[g]),
         .i_data  (w_data[g]),
         .o_ready (w_rdy_up),
         .i_ready (w_rdy_dn),
         .o_valid (w_valid[g+1]),
         .o_data  (w_data[g+1])
      );
   end

   assign in_ready  = g_stage[0].w_rdy_up;
   assign out_valid = w_valid[STAGES];
   assign data_out  = w_data[STAGES][WIDTH-1:0];
   assign ovf       = w_data[STAGES][WIDTH];
   assign acc       = r_acc;

endmodule
